regbank: RTL and testbench

REGBANK -- requirements
Module: regbank

---
 rtl/regbank_pkg.sv | 12 +
 rtl/regbank_clrseq.sv | 51 +++++
 rtl/regbank.sv | 78 +++++++
 tb/tb_regbank.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types and default sizing for the regbank register file and its clear sequencer.
package regbank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 16;

endpackage

// File: rtl/regbank_clrseq.sv
// Clear sequencer: walks cnt from 1 to NREGS-1, one register per cycle, and flags busy meanwhile.
module regbank_clrseq
  import regbank_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] cnt,
  output logic          clr_stb
);

  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = AW'(NREGS - 1);

  state_t state, state_nxt;

  // NOTE: state is updated with <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt is assigned before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter re-arms to 1 on the final sweep edge, ready for the next clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= CNT_FIRST;
    end else if (state == CLEAR) begin
      if (cnt == CNT_LAST) cnt <= CNT_FIRST;
      else                 cnt <= cnt + AW'(1);
    end
  end

  // Decoded from the state flop only, so clr never reaches busy combinationally.
  assign busy    = (state == CLEAR);
  assign clr_stb = (state == CLEAR);

endmodule

// File: rtl/regbank.sv
// Register file with hard-wired zero register, two read ports and a runtime clear sweep.
// Optional same-cycle write-through on the read ports when REGBANK_BYPASS_EN is defined.
module regbank
  import regbank_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             clr,
  output logic             busy,
  output logic             wr_rej
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    cnt;
  logic             clr_stb;
  logic             wr_ok;
  logic [WIDTH-1:0] stored1, stored2;

  // Register 0 and any address beyond the bank are never storage targets.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && (a != '0);
  endfunction

  regbank_clrseq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clrseq (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .busy    (busy),
    .cnt     (cnt),
    .clr_stb (clr_stb)
  );

  assign wr_ok = we3 && !busy && addr_live(wa3);

  // NOTE: the array is reset element by element; reset is its only initial content,
  // which rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wr_rej <= 1'b0;
    end else begin
      wr_rej <= we3 && busy;
      if (clr_stb)    regs[cnt] <= '0;
      else if (wr_ok) regs[wa3] <= wd3;
    end
  end

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (addr_live(ra1)) stored1 = regs[ra1];
    if (addr_live(ra2)) stored2 = regs[ra2];
  end

`ifdef REGBANK_BYPASS_EN
  // wr_ok already implies idle, a live address and an active write.
  assign rd1 = (wr_ok && (wa3 == ra1)) ? wd3 : stored1;
  assign rd2 = (wr_ok && (wa3 == ra2)) ? wd3 : stored2;
`else
  assign rd1 = stored1;
  assign rd2 = stored2;
`endif

endmodule

// File: tb/tb_regbank.sv
// Self-checking bench for regbank: directed scenarios plus a randomized run against a behavioural model.
module tb_regbank;

  localparam int WIDTH   = 8;
  localparam int NREGS   = 16;
  localparam int AW      = 4;
  localparam int NREGS_B = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             we3, clr;
  logic [AW-1:0]    wa3, ra1, ra2;
  logic [WIDTH-1:0] wd3, rd1, rd2;
  logic             busy, wr_rej;

  logic             we3_b, clr_b;
  logic [3:0]       wa3_b, ra1_b, ra2_b;
  logic [7:0]       wd3_b, rd1_b, rd2_b;
  logic             busy_b, wr_rej_b;

  always #5 clk = ~clk;

  regbank #(.WIDTH(WIDTH), .NREGS(NREGS)) u_dut (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .clr(clr), .busy(busy), .wr_rej(wr_rej)
  );

  // Non-power-of-two bank so out-of-range addresses are reachable.
  regbank #(.WIDTH(8), .NREGS(NREGS_B)) u_dut_b (
    .clk(clk), .reset(reset), .we3(we3_b), .wa3(wa3_b), .wd3(wd3_b),
    .ra1(ra1_b), .ra2(ra2_b), .rd1(rd1_b), .rd2(rd2_b),
    .clr(clr_b), .busy(busy_b), .wr_rej(wr_rej_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: register contents, sweep position and pending reject flag.
  int mem [NREGS];
  bit m_busy;
  int m_pos;
  bit m_rej;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mem[i] = 0;
    m_busy = 1'b0;
    m_pos  = 1;
    m_rej  = 1'b0;
  endtask

  function automatic int exp_rd(input int a);
    if (a == 0 || a >= NREGS) return 0;
`ifdef REGBANK_BYPASS_EN
    if (!m_busy && we3 && int'(wa3) == a) return int'(wd3);
`endif
    return mem[a];
  endfunction

  task automatic sample(input string tag);
    @(negedge clk);
    check({tag, "/rd1"},    32'(rd1),    32'(exp_rd(int'(ra1))));
    check({tag, "/rd2"},    32'(rd2),    32'(exp_rd(int'(ra2))));
    check({tag, "/busy"},   32'(busy),   32'(m_busy));
    check({tag, "/wr_rej"}, 32'(wr_rej), 32'(m_rej));
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_rej = we3 && m_busy;
      if (m_busy) begin
        mem[m_pos] = 0;
        if (m_pos == NREGS - 1) m_busy = 1'b0;
        else                    m_pos++;
      end else begin
        if (we3 && wa3 != '0) mem[wa3] = int'(wd3);
        if (clr) begin
          m_busy = 1'b1;
          m_pos  = 1;
        end
      end
    end
    #1;
  endtask

  task automatic tick(input string tag);
    sample(tag);
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcount;
    reset = 1'b0;
    we3 = 0; clr = 0; wa3 = '0; wd3 = '0; ra1 = 4'd3; ra2 = 4'd15;
    we3_b = 0; clr_b = 0; wa3_b = '0; wd3_b = '0; ra1_b = '0; ra2_b = '0;
    model_reset();

    // Reset state
    #12;
    check("rst/busy",   32'(busy),   32'd0);
    check("rst/wr_rej", 32'(wr_rej), 32'd0);
    check("rst/rd1",    32'(rd1),    32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic write and dual-port read; writes to r0 have no effect
    we3 = 1; wa3 = 4'd3; wd3 = 8'hA5; ra1 = 4'd3; ra2 = 4'd3;
    tick("w_r3");
    we3 = 0;
    sample("r_r3");
    check("r3/rd1", 32'(rd1), 32'hA5);
    check("r3/rd2", 32'(rd2), 32'hA5);
    advance();
    we3 = 1; wa3 = 4'd0; wd3 = 8'h7F; ra1 = 4'd0;
    tick("w_r0");
    we3 = 0;
    sample("r_r0");
    check("r0/rd1", 32'(rd1), 32'd0);
    advance();

    // Same-cycle write visibility on a read port
    we3 = 1; wa3 = 4'd2; wd3 = 8'hC3; ra1 = 4'd2;
    sample("byp_same");
`ifdef REGBANK_BYPASS_EN
    check("byp/same", 32'(rd1), 32'hC3);
`else
    check("byp/same", 32'(rd1), 32'd0);
`endif
    advance();
    we3 = 0;
    sample("byp_next");
    check("byp/next", 32'(rd1), 32'hC3);
    advance();

    // Preload r1..r15, sweep, mid-sweep reads; a second clr during the sweep is ignored
    for (int i = 1; i < NREGS; i++) begin
      we3 = 1; wa3 = AW'(i); wd3 = 8'(8'h10 + i);
      tick("preload");
    end
    we3 = 0; clr = 1;
    tick("clr_go");
    clr = 0;
    bcount = 0;
    for (int k = 1; k <= 20; k++) begin
      clr = (k == 3);
      ra1 = (k == 8) ? 4'd5  : AW'($urandom_range(NREGS - 1));
      ra2 = (k == 8) ? 4'd12 : AW'($urandom_range(NREGS - 1));
      sample("sweep");
      if (k == 8) begin
        check("mid/r5",  32'(rd1), 32'd0);
        check("mid/r12", 32'(rd2), 32'h1C);
      end
      if (busy) bcount++;
      advance();
    end
    clr = 0;
    check("sweep/len", 32'(bcount), 32'd15);
    for (int i = 0; i < NREGS; i++) begin
      ra1 = AW'(i); ra2 = AW'(NREGS - 1 - i);
      sample("post_sweep");
      check("post/rd1", 32'(rd1), 32'd0);
      advance();
    end

    // Write during sweep is rejected with a one-cycle wr_rej pulse
    clr = 1;
    tick("clr2");
    clr = 0;
    tick("sw1");
    tick("sw2");
    we3 = 1; wa3 = 4'd4; wd3 = 8'h11;
    tick("sw_wr");
    we3 = 0;
    sample("rej1");
    check("rej/pulse", 32'(wr_rej), 32'd1);
    advance();
    sample("rej2");
    check("rej/drop", 32'(wr_rej), 32'd0);
    advance();
    for (int k = 0; k < 20 && m_busy; k++) tick("sw_rest");
    ra1 = 4'd4;
    sample("r4");
    check("rej/r4", 32'(rd1), 32'd0);
    advance();

    // clr and write in the same idle cycle: write lands, sweep then clears it
    we3 = 1; wa3 = 4'd9; wd3 = 8'h33; clr = 1; ra1 = 4'd9;
    tick("clr_wr");
    we3 = 0; clr = 0;
    sample("r9_live");
    check("r9/live", 32'(rd1), 32'h33);
    advance();
    for (int k = 0; k < 20 && m_busy; k++) tick("sw9");
    sample("r9_after");
    check("r9/after", 32'(rd1), 32'd0);
    advance();

    // Reset during sweep cycle 6
    we3 = 1; wa3 = 4'd7; wd3 = 8'h5A;
    tick("pre7");
    we3 = 0; clr = 1;
    tick("clr3");
    clr = 0;
    for (int k = 1; k <= 5; k++) tick("sw_rst");
    #2 reset = 1'b0;
    #1;
    check("arst/busy",   32'(busy),   32'd0);
    check("arst/wr_rej", 32'(wr_rej), 32'd0);
    ra1 = 4'd7;
    #1;
    check("arst/r7", 32'(rd1), 32'd0);
    model_reset();
    @(posedge clk); #3 reset = 1'b1;
    tick("post_rst");
    clr = 1;
    tick("clr4");
    clr = 0;
    bcount = 0;
    for (int k = 0; k < 20; k++) begin
      ra1 = AW'($urandom_range(NREGS - 1)); ra2 = ra1;
      sample("sweep4");
      if (busy) bcount++;
      advance();
    end
    check("sweep4/len", 32'(bcount), 32'd15);

    // Out-of-range addresses on a 12-entry bank
    we3_b = 1; wa3_b = 4'd13; wd3_b = 8'h55; ra1_b = 4'd13; ra2_b = 4'd11;
    tick("b_oob");
    we3_b = 1; wa3_b = 4'd11; wd3_b = 8'h66;
    tick("b_top");
    we3_b = 0;
    @(negedge clk);
    check("b/oob_rd",  32'(rd1_b),    32'd0);
    check("b/oob_rej", 32'(wr_rej_b), 32'd0);
    check("b/top_rd",  32'(rd2_b),    32'h66);
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we3 = 1'($urandom_range(1));
      wa3 = AW'($urandom_range(NREGS - 1));
      wd3 = WIDTH'($urandom_range(255));
      clr = ($urandom_range(15) == 0);
      ra1 = AW'($urandom_range(NREGS - 1));
      ra2 = ($urandom_range(3) == 0) ? ra1 : AW'($urandom_range(NREGS - 1));
      tick("rand");
    end
    we3 = 0; clr = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
